vga_spi_line_fetch: RTL and testbench
=====================================

// Module: vga_spi_line_fetch
// PURPOSE
// Downstream consumer of the VGA timing generator (hpos/vpos/hmax/vmax/visible).
// Streams one 1bpp scanline per line period from SPI ROM into a ping-pong line buffer,
// using a mode-0 READ (0x03). Drives o_pixel from the other buffer during the visible area.
// Each ROM bit is repeated 2**PIXEL_SHIFT pixels horizontally (default 160 bits -> 640 px).
// PARAMETERS
// LINE_BITS   160       ROM bits per scanline; must be a multiple of 8 (LINE_BYTES = LINE_BITS/8)
// PIXEL_SHIFT 2         log2 horizontal pixel repeat; H_VIEW >> PIXEL_SHIFT <= LINE_BITS
// V_VIEW      480       visible lines; fetch is suppressed for lines >= V_VIEW
// V_TOTAL     525       total lines per frame (vmax line = V_TOTAL-1)
// BASE_ADDR   24'h0     ROM byte address of line 0
// PORTS
// clk        in   1   pixel clock
// reset      in   1   synchronous, active-high
// i_hpos     in   10  from timing generator
// i_vpos     in   10  from timing generator
// i_hmax     in   1   last clock of line
// i_vmax     in   1   last line of frame
// i_visible  in   1   in visible area
// spi_cs_n   out  1   ROM chip select, active low
// spi_sclk   out  1   SPI clock, clk/2, idle low (mode 0)
// spi_mosi   out  1   command/address, MSB first
// spi_miso   in   1   ROM data
// o_pixel    out  1   pixel, registered; 0 outside visible area
// o_busy     out  1   SPI transaction in progress (= ~spi_cs_n)
// o_underrun out  1   1-clk pulse: buffer swap wanted but fetch incomplete
// BEHAVIOUR
// Reset: spi_cs_n=1, sclk=0, mosi=0, o_pixel=0, o_underrun=0.
//   Reset also clears both buffers, fill_ready=0, disp_sel=0 and state=IDLE. Reset mid-fetch aborts it.
// Line numbering at i_hmax: next n = i_vmax ? 0 : i_vpos+1.
//   Fetch target f = (n==V_TOTAL-1) ? 0 : n+1, i.e. one line ahead of display.
// Fetch start: state IDLE and i_hmax=1 and f<V_VIEW -> CMD on the next clk.
//   addr = BASE_ADDR + f*LINE_BYTES, truncated to 24 bits.
// FSM: IDLE -> CMD(8 bits 0x03) -> ADDR(24 bits) -> DATA(LINE_BITS bits) -> IDLE.
// Bit timing: 2 clks per bit.
//   Phase 0: sclk=0, mosi=current bit. Phase 1: sclk=1.
//   miso is sampled on the clk ending phase 1.
//   cs_n falls with phase 0 of the first cmd bit. cs_n rises (sclk=0) on the clk after the last data phase 1.
//   Whole transaction: (32+LINE_BITS)*2 clks with cs_n low (384 by default).
// DATA: the first received bit is stored as pixel 0 of the fill buffer (!disp_sel); mosi=0 during DATA.
//   Last bit sampled -> fill_ready=1.
// Swap on i_hmax, same clk as the fetch decision:
//   fill_ready=1 -> disp_sel toggles, fill_ready=0.
//   Else, if n<V_VIEW -> o_underrun=1 for 1 clk; disp_sel unchanged (previous line repeats).
// Overrun: i_hmax while not IDLE -> abort.
//   Abort: cs_n=1 and sclk=0 that clk, state=IDLE, partial data discarded, o_underrun pulses.
//   New fetch starts the following clk. cs_n is therefore high for >=1 clk between transactions.
// Pixel: o_pixel <= i_visible ? disp_buf[i_hpos>>PIXEL_SHIFT] : 0.
//   Latency: 1 clk after i_hpos.
//   Index out of range (>= LINE_BITS) -> 0.
// Simultaneous: the fetch-complete bit on the same clk as i_hmax counts as complete, so no underrun.
// TESTING
// 1 Reset asserted 3 clks mid-transaction -> next clk cs_n=1, sclk=0, o_pixel=0.
//   Reset also leaves o_busy=0 and both buffers zero.
// 2 i_hmax with i_vpos=0 -> mosi shifts 0x03 then 0x000028.
//   Expect 192 sclk rising edges, cs_n low for exactly 384 clks, then o_busy=0.
// 3 ROM model line 1 = 0xA5,0x00..: after swap, hpos 0-3 -> o_pixel=1, hpos 4-7 -> 0, hpos 8-11 -> 1.
//   Each o_pixel value appears 1 clk after its hpos; 0 when i_visible=0.
// 4 Frame wrap: hmax at vpos=523 fetches addr 0x000000; hmax with i_vmax (vpos=524) fetches 0x000014.
//   hmax at vpos 478..522 -> no cs_n activity.
// 5 Short line (i_hmax 200 clks apart) -> abort: cs_n high for 1 clk, o_underrun 1 clk.
//   Same display line repeats, new fetch starts, address matches the new f.
// 6 First frame after reset: hmax at vpos 0 with fill_ready=0 -> o_underrun pulses.
//   Line 1 shows all-zero pixels; line 2 shows fetched data.

Source files
------------

// File: rtl/vga_spi_line_fetch.sv
// vga_spi_line_fetch: streams one 1bpp scanline per line period from an SPI ROM
// (mode 0, READ 0x03) into a ping-pong line buffer and drives pixels from the other half.
// Ports:
//   clk, reset             pixel clock, synchronous active-high reset
//   i_hpos, i_vpos         beam position from the timing generator
//   i_hmax, i_vmax         last clock of line / last line of frame
//   i_visible              beam inside the visible area
//   spi_cs_n, spi_sclk     ROM chip select (low active), SPI clock at clk/2 idling low
//   spi_mosi, spi_miso     command/address out MSB first, ROM data in
//   o_pixel                registered pixel, 0 outside the visible area
//   o_busy                 SPI transaction in progress
//   o_underrun             1-clk pulse when a line swap or fetch could not complete
module vga_spi_line_fetch #(
   parameter int          LINE_BITS   = 160,
   parameter int          PIXEL_SHIFT = 2,
   parameter int          V_VIEW      = 480,
   parameter int          V_TOTAL     = 525,
   parameter logic [23:0] BASE_ADDR   = 24'h0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] i_hpos,
   input  logic [9:0] i_vpos,
   input  logic       i_hmax,
   input  logic       i_vmax,
   input  logic       i_visible,
   output logic       spi_cs_n,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       o_pixel,
   output logic       o_busy,
   output logic       o_underrun
);
   localparam int LINE_BYTES = LINE_BITS / 8;
   localparam int CW = $clog2(LINE_BITS > 24 ? LINE_BITS : 24);
   typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;
   state_t state;
   logic ph, pend, fill_ready, disp_sel;
   logic [CW-1:0] cnt;
   logic [31:0] sh;
   logic [23:0] pend_addr, addr, saddr;
   logic [LINE_BITS-1:0] buf0, buf1, disp_buf, pix;
   logic [9:0] n, f, idx;
   logic go, last, done, start;
   assign o_busy = ~spi_cs_n;
   always_comb begin
      n        = i_vmax ? 10'd0 : i_vpos + 10'd1;
      f        = (n == 10'(V_TOTAL - 1)) ? 10'd0 : n + 10'd1;
      go       = f < 10'(V_VIEW);
      addr     = BASE_ADDR + 24'(f) * 24'(LINE_BYTES);
      last     = (state == CMD)  ? cnt == CW'(7) :
                 (state == ADDR) ? cnt == CW'(23) : cnt == CW'(LINE_BITS - 1);
      done     = state == DATA && ph && cnt == CW'(LINE_BITS - 1);
      // a fetch requested while a transaction was being aborted starts one clk later
      start    = state == IDLE && (i_hmax ? go : pend);
      saddr    = i_hmax ? addr : pend_addr;
      idx      = i_hpos >> PIXEL_SHIFT;
      disp_buf = disp_sel ? buf1 : buf0;
      // shifting the line right makes out-of-range indices read as 0
      pix      = disp_buf >> idx;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ph         <= 1'b0;
         cnt        <= '0;
         sh         <= '0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         fill_ready <= 1'b0;
         disp_sel   <= 1'b0;
         buf0       <= '0;
         buf1       <= '0;
         spi_cs_n   <= 1'b1;
         spi_sclk   <= 1'b0;
         spi_mosi   <= 1'b0;
         o_pixel    <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         o_pixel    <= i_visible & pix[0];
         o_underrun <= 1'b0;
         if (start) begin
            state    <= CMD;
            ph       <= 1'b0;
            cnt      <= '0;
            pend     <= 1'b0;
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            sh       <= {8'h03, saddr} << 1;
         end else if (state != IDLE) begin
            ph       <= ~ph;
            spi_sclk <= ~ph;
            if (ph) begin
               spi_mosi <= sh[31];
               sh       <= {sh[30:0], 1'b0};
               cnt      <= last ? '0 : cnt + 1'b1;
               if (state == DATA) begin
                  if (disp_sel) buf0[cnt] <= spi_miso;
                  else buf1[cnt] <= spi_miso;
               end
               if (last) begin
                  state <= (state == CMD) ? ADDR : (state == ADDR) ? DATA : IDLE;
                  if (state == DATA) begin
                     spi_cs_n   <= 1'b1;
                     fill_ready <= 1'b1;
                  end
               end
            end
         end
         if (i_hmax) begin
            // a fetch finishing on this very clk still counts as complete
            if (fill_ready || done) begin
               disp_sel   <= ~disp_sel;
               fill_ready <= 1'b0;
            end else if (n < 10'(V_VIEW)) o_underrun <= 1'b1;
            if (state != IDLE) begin
               state     <= IDLE;
               spi_cs_n  <= 1'b1;
               spi_sclk  <= 1'b0;
               spi_mosi  <= 1'b0;
               pend      <= go;
               pend_addr <= addr;
               if (!done) o_underrun <= 1'b1;
            end else pend <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vga_spi_line_fetch.sv
// tb_vga_spi_line_fetch: directed bench with an SPI ROM model and pixel vector tables.
module tb_vga_spi_line_fetch;
   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] i_hpos, i_vpos;
   logic       i_hmax, i_vmax, i_visible;
   logic       spi_cs_n, spi_sclk, spi_mosi;
   logic       spi_miso = 1'b0;
   logic       o_pixel, o_busy, o_underrun;
   int checks = 0;
   int errors = 0;

   vga_spi_line_fetch dut (
      .clk(clk), .reset(reset), .i_hpos(i_hpos), .i_vpos(i_vpos), .i_hmax(i_hmax),
      .i_vmax(i_vmax), .i_visible(i_visible), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .o_pixel(o_pixel), .o_busy(o_busy),
      .o_underrun(o_underrun)
   );

   always #5 clk = ~clk;

   // ROM: 20 bytes per line; byte 0 tags the line, byte 19 = 0x01 marks the last pixel
   function automatic logic [7:0] rom_byte(input logic [23:0] a);
      int l = int'(a / 20);
      int o = int'(a % 20);
      if (o == 19) return 8'h01;
      if (o != 0) return 8'h00;
      if (l == 1) return 8'hA5;
      if (l == 2) return 8'h3C;
      return 8'(l);
   endfunction

   int          mbits = 0;
   logic [31:0] mrx = '0;
   logic [7:0]  mcmd = '0;
   logic [23:0] maddr = '0;

   always @(posedge spi_sclk or posedge spi_cs_n) begin
      if (spi_cs_n) mbits = 0;
      else begin
         mrx = {mrx[30:0], spi_mosi};
         mbits++;
         if (mbits == 32) begin
            mcmd  = mrx[31:24];
            maddr = mrx[23:0];
         end
      end
   end

   always @(negedge spi_sclk) begin
      logic [7:0] t;
      int k;
      if (!spi_cs_n && mbits >= 32) begin
         k = mbits - 32;
         t = rom_byte(maddr + 24'(k / 8)) << (k % 8);
         spi_miso = t[7];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hmax_step(input logic [9:0] v, input logic vm);
      i_vpos = v;
      i_vmax = vm;
      i_hmax = 1'b1;
      step();
      i_hmax = 1'b0;
      i_vmax = 1'b0;
   endtask

   // called right after the clk on which cs_n fell
   task automatic fetch_check(input logic [23:0] exp_addr, input string nm);
      int low, rises;
      logic prev;
      low   = spi_cs_n ? 0 : 1;
      rises = 0;
      prev  = spi_sclk;
      for (int i = 0; i < 1000 && !spi_cs_n; i++) begin
         step();
         if (!spi_cs_n) low++;
         if (spi_sclk && !prev) rises++;
         prev = spi_sclk;
      end
      chk({nm, " cs_low"}, low, 384);
      chk({nm, " sclk_rises"}, rises, 192);
      chk({nm, " busy_end"}, o_busy, 0);
      chk({nm, " cmd"}, mcmd, 8'h03);
      chk({nm, " addr"}, maddr, exp_addr);
   endtask

   typedef struct {
      int         grp;
      logic [9:0] hpos;
      logic       vis;
      logic       exp;
   } vec_t;
   vec_t vecs[48];
   int nv = 0;

   task automatic add(input int g, input logic [9:0] h, input logic v, input logic e);
      vecs[nv] = '{grp: g, hpos: h, vis: v, exp: e};
      nv++;
   endtask

   task automatic run_table(input int g);
      for (int i = 0; i < nv; i++)
         if (vecs[i].grp == g) begin
            i_hpos    = vecs[i].hpos;
            i_visible = vecs[i].vis;
            step();
            chk($sformatf("pix g%0d h%0d v%0d", g, vecs[i].hpos, vecs[i].vis), o_pixel, vecs[i].exp);
         end
      i_visible = 1'b0;
   endtask

   initial begin
      int lows, unds;
      // 0: zero buffer; 1: line 2 (0x3C); 2: line 1 (0xA5); 3: after reset; 4: line 12 (0x0C)
      add(0, 0, 1, 0);   add(0, 8, 1, 0);   add(0, 636, 1, 0);
      add(1, 0, 1, 0);   add(1, 7, 1, 0);   add(1, 8, 1, 1);   add(1, 23, 1, 1);
      add(1, 24, 1, 0);  add(1, 12, 0, 0);  add(1, 632, 1, 0); add(1, 636, 1, 1);
      add(1, 639, 1, 1); add(1, 640, 1, 0); add(1, 1023, 1, 0);
      add(2, 0, 1, 1);   add(2, 3, 1, 1);   add(2, 4, 1, 0);   add(2, 7, 1, 0);
      add(2, 8, 1, 1);   add(2, 11, 1, 1);  add(2, 12, 1, 0);  add(2, 20, 1, 1);
      add(2, 28, 1, 1);  add(2, 0, 0, 0);   add(2, 636, 1, 1); add(2, 640, 1, 0);
      add(3, 636, 1, 0); add(3, 8, 1, 0);   add(3, 0, 1, 0);
      add(4, 16, 1, 1);  add(4, 0, 1, 0);   add(4, 24, 1, 0);

      reset = 1'b1; i_hpos = '0; i_vpos = '0; i_hmax = 0; i_vmax = 0; i_visible = 0;
      repeat (3) step();
      chk("rst cs_n", spi_cs_n, 1);
      chk("rst sclk", spi_sclk, 0);
      chk("rst mosi", spi_mosi, 0);
      chk("rst pixel", o_pixel, 0);
      chk("rst underrun", o_underrun, 0);
      chk("rst busy", o_busy, 0);
      reset = 1'b0;
      step();

      // first line after reset: nothing to swap in, fetch line 2
      hmax_step(0, 0);
      chk("first underrun", o_underrun, 1);
      chk("first cs_n", spi_cs_n, 0);
      chk("first busy", o_busy, 1);
      fetch_check(24'h000028, "f_l2");
      run_table(0);
      hmax_step(1, 0);
      chk("swap1 underrun", o_underrun, 0);
      fetch_check(24'h00003C, "f_l3");
      run_table(1);

      // lines beyond the visible area never fetch
      lows = 0; unds = 0;
      for (int v = 478; v <= 522; v++) begin
         hmax_step(10'(v), 0);
         if (!spi_cs_n) lows++;
         if (o_underrun) unds++;
         repeat (3) begin
            step();
            if (!spi_cs_n) lows++;
            if (o_underrun) unds++;
         end
      end
      chk("blank cs_low", lows, 0);
      chk("blank underruns", unds, 0);

      hmax_step(523, 0);
      fetch_check(24'h000000, "f_l0");
      hmax_step(524, 1);
      fetch_check(24'h000014, "f_l1");
      hmax_step(0, 0);
      chk("swap_l1 underrun", o_underrun, 0);
      fetch_check(24'h000028, "f_l2b");
      run_table(2);

      // short line aborts the running fetch
      hmax_step(1, 0);
      repeat (199) step();
      chk("short busy", o_busy, 1);
      hmax_step(2, 0);
      chk("abort cs_n", spi_cs_n, 1);
      chk("abort sclk", spi_sclk, 0);
      chk("abort underrun", o_underrun, 1);
      step();
      chk("restart cs_n", spi_cs_n, 0);
      chk("restart underrun", o_underrun, 0);
      fetch_check(24'h000050, "f_l4");
      run_table(1);

      // line end on the clk that samples the last data bit
      hmax_step(10, 0);
      repeat (383) step();
      chk("sim busy", o_busy, 1);
      hmax_step(11, 0);
      chk("sim underrun", o_underrun, 0);
      chk("sim cs_n", spi_cs_n, 1);
      step();
      chk("sim restart cs_n", spi_cs_n, 0);
      fetch_check(24'h000104, "f_l13");
      run_table(4);

      // reset in the middle of a transaction
      hmax_step(20, 0);
      repeat (50) step();
      i_visible = 1'b1;
      i_hpos = 10'd636;
      reset = 1'b1;
      step();
      chk("mid rst cs_n", spi_cs_n, 1);
      chk("mid rst sclk", spi_sclk, 0);
      chk("mid rst pixel", o_pixel, 0);
      chk("mid rst busy", o_busy, 0);
      repeat (2) step();
      reset = 1'b0;
      i_visible = 1'b0;
      step();
      chk("post rst busy", o_busy, 0);
      run_table(3);
      hmax_step(0, 0);
      chk("post rst underrun", o_underrun, 1);
      chk("post rst fetch", spi_cs_n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
